coax_buffered_tx_ctrl: RTL

COAX_BUFFERED_TX_CTRL -- requirements
Module: coax_buffered_tx_ctrl

---
 rtl/coax_buffered_tx_ctrl_if.sv | 34 +++
 rtl/coax_buffered_tx_ctrl.sv | 100 ++++++++++
 2 files changed

// File: rtl/coax_buffered_tx_ctrl_if.sv
// Handshake/bus bundle for coax_buffered_tx_ctrl: enqueue side, transmit side
// and FIFO status. master drives the block's inputs; slave is the controller.
interface coax_buffered_tx_ctrl_if #(
  parameter int DATA_WIDTH = 10,
  parameter int DEPTH      = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DATA_WIDTH-1:0] data;
  logic                  load_strobe;
  logic                  start_strobe;
  logic                  abort_strobe;
  logic                  error_clear;
  logic                  parity;
  logic                  tx_ready;
  logic [DATA_WIDTH:0]   tx_data;
  logic                  tx_strobe;
  logic                  tx_active;
  logic                  done;
  logic [CW-1:0]         count;
  logic                  empty;
  logic                  full;
  logic                  overflow;

  modport master (
    output data, load_strobe, start_strobe, abort_strobe, error_clear, parity, tx_ready,
    input  tx_data, tx_strobe, tx_active, done, count, empty, full, overflow
  );

  modport slave (
    input  data, load_strobe, start_strobe, abort_strobe, error_clear, parity, tx_ready,
    output tx_data, tx_strobe, tx_active, done, count, empty, full, overflow
  );
endinterface

// File: rtl/coax_buffered_tx_ctrl.sv
// Buffered coax word transmitter: circular FIFO feeding a serializer through an
// IDLE/SEND/HOLD frame controller with parity insertion and sticky overflow.
module coax_buffered_tx_ctrl #(
  parameter int DATA_WIDTH  = 10,
  parameter int DEPTH       = 16,
  parameter int START_DEPTH = 4,
  parameter int AUTO_START  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  coax_buffered_tx_ctrl_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, SEND, HOLD} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         rd_ptr, wr_ptr;
  logic [CW-1:0]         count_q;
  logic                  overflow_q;
  logic                  tx_strobe_q;
  logic                  done_q;
  logic [DATA_WIDTH:0]   tx_data_q;

  logic                  empty_w, full_w;
  logic                  pop, push, ovf_set, frame_end, start_ok;
  logic [DATA_WIDTH-1:0] head;

  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == CW'(DEPTH));
  assign head    = mem[rd_ptr];

  // Abort outranks every other request; a pop frees a slot so a load into a full FIFO still lands.
  always_comb begin
    pop       = (state_q == SEND) && bus.tx_ready && !empty_w && !bus.abort_strobe;
    push      = bus.load_strobe && (!full_w || pop) && !bus.abort_strobe;
    ovf_set   = bus.load_strobe && full_w && !pop && !bus.abort_strobe;
    frame_end = (state_q == SEND) && bus.tx_ready && empty_w && !bus.abort_strobe;
    start_ok  = (bus.start_strobe && !empty_w) ||
                ((AUTO_START != 0) && (count_q >= CW'(START_DEPTH)));
  end

  always_comb begin
    state_d = state_q;
    if (bus.abort_strobe) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start_ok) state_d = SEND;
        SEND:    if (bus.tx_ready) state_d = empty_w ? IDLE : HOLD;
        HOLD:    state_d = SEND;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      tx_strobe_q <= 1'b0;
      done_q      <= 1'b0;
      tx_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      tx_strobe_q <= pop;
      done_q      <= frame_end;
      overflow_q  <= ovf_set | (overflow_q & ~bus.error_clear);
      if (bus.abort_strobe) begin
        rd_ptr  <= '0;
        wr_ptr  <= '0;
        count_q <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        if (push && !pop)      count_q <= count_q + CW'(1);
        else if (pop && !push) count_q <= count_q - CW'(1);
      end
      if (pop) tx_data_q <= {(^head) ^ bus.parity, head};
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.data;
  end

  assign bus.tx_data   = tx_data_q;
  assign bus.tx_strobe = tx_strobe_q;
  assign bus.tx_active = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.count     = count_q;
  assign bus.empty     = empty_w;
  assign bus.full      = full_w;
  assign bus.overflow  = overflow_q;
endmodule
